// File: rtl/jtkicker_ioctl_tx.sv
// Purpose: ioctl download/upload transmitter for the Kicker game cores. It paces host bytes into ioctl writes and walks addresses to dump NVRAM back to the host.
// Latency: a byte accepted at edge N produces ioctl_wr in cycle N+1, with writes at least GAP cycles apart. An upload byte takes RDLAT+2 cycles when host_ordy is held high.
// Backpressure: host_rdy is raised only while waiting for a download byte. host_ov holds until host_ordy. Optional JTKICKER_IOCTL_CKSUM_EN adds the cksum output.
module jtkicker_ioctl_tx #(
  parameter int AW    = 22,
  parameter int GAP   = 8,
  parameter int RDLAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic          cmd_up,
  input  logic          cmd_ram,
  input  logic [AW-1:0] cmd_len,
  input  logic [7:0]    host_din,
  input  logic          host_dv,
  output logic          host_rdy,
  output logic [7:0]    host_dout,
  output logic          host_ov,
  input  logic          host_ordy,
  output logic          busy,
  output logic          done,
`ifdef JTKICKER_IOCTL_CKSUM_EN
  output logic [7:0]    cksum,
`endif
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_dout,
  output logic          ioctl_wr,
  output logic          ioctl_rom,
  output logic          ioctl_ram,
  input  logic [7:0]    ioctl_din
);

  // One timer serves both the write gap and the read latency.
  localparam int TMAX = (GAP > RDLAT) ? GAP : RDLAT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, DL_WAIT, DL_WR, DL_GAP, UL_ADDR, UL_WAIT, UL_OUT, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    hdout_q, hdout_d;
  logic          wr_q, wr_d;
  logic          rom_q, rom_d;
  logic          ram_q, ram_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdy_q, rdy_d;
  logic          ov_q, ov_d;
  logic [7:0]    cks_q, cks_d;
  logic          last_beat;

  // The byte now finishing is the last of the command.
  assign last_beat = ((cnt_q + AW'(1)) == len_q);

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    dout_d  = dout_q;
    hdout_d = hdout_q;
    rom_d   = rom_q;
    ram_d   = ram_q;
    busy_d  = busy_q;
    ov_d    = ov_q;
    cks_d   = cks_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          len_d  = cmd_len;
          addr_d = '0;
          cnt_d  = '0;
          cks_d  = 8'h00;
          busy_d = 1'b1;
          rom_d  = ~cmd_ram;
          ram_d  = cmd_ram;
          if (cmd_len == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = cmd_up ? UL_ADDR : DL_WAIT;
          end
        end
      end
      DL_WAIT: begin
        if (host_dv && rdy_q) begin
          dout_d  = host_din;
          wr_d    = 1'b1;
          tmr_d   = TW'(GAP - 1);
          cks_d   = cks_q + host_din;
          state_d = DL_WR;
        end
      end
      // The write cycle counts as the first cycle of the gap window, so writes land exactly GAP apart when the host never stalls.
      DL_WR, DL_GAP: begin
        if (tmr_q <= TW'(1)) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + AW'(1);
          if (last_beat) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = DL_WAIT;
          end
        end else begin
          tmr_d   = tmr_q - TW'(1);
          state_d = DL_GAP;
        end
      end
      UL_ADDR: begin
        tmr_d   = TW'(RDLAT);
        state_d = UL_WAIT;
      end
      UL_WAIT: begin
        if (tmr_q <= TW'(1)) begin
          hdout_d = ioctl_din;
          ov_d    = 1'b1;
          cks_d   = cks_q + ioctl_din;
          state_d = UL_OUT;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      UL_OUT: begin
        if (host_ordy) begin
          ov_d   = 1'b0;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + AW'(1);
          if (last_beat) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = UL_ADDR;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        rom_d   = 1'b0;
        ram_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == DL_WAIT);
  end

  // State and registered outputs. Reset clears everything at once, which also aborts a transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      dout_q  <= 8'h00;
      hdout_q <= 8'h00;
      wr_q    <= 1'b0;
      rom_q   <= 1'b0;
      ram_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ov_q    <= 1'b0;
      cks_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      dout_q  <= dout_d;
      hdout_q <= hdout_d;
      wr_q    <= wr_d;
      rom_q   <= rom_d;
      ram_q   <= ram_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      ov_q    <= ov_d;
      cks_q   <= cks_d;
    end
  end

  assign host_rdy   = rdy_q;
  assign host_dout  = hdout_q;
  assign host_ov    = ov_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ioctl_addr = addr_q;
  assign ioctl_dout = dout_q;
  assign ioctl_wr   = wr_q;
  assign ioctl_rom  = rom_q;
  assign ioctl_ram  = ram_q;

`ifdef JTKICKER_IOCTL_CKSUM_EN
  assign cksum = cks_q;
`else
  // The running sum has no consumer in this build.
  logic cks_unused;
  assign cks_unused = ^cks_q;
`endif

endmodule

// File: tb/tb_jtkicker_ioctl_tx.sv
module tb_jtkicker_ioctl_tx;
  localparam int AW = 22, GAP = 8, RDLAT = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_start = 1'b0, cmd_up = 1'b0, cmd_ram = 1'b0;
  logic [AW-1:0] cmd_len = '0;
  logic [7:0] host_din = 8'h00;
  logic host_dv = 1'b0, host_ordy = 1'b0;
  logic host_rdy, host_ov, busy, done, ioctl_wr, ioctl_rom, ioctl_ram;
  logic [7:0] host_dout, ioctl_dout, ioctl_din;
  logic [AW-1:0] ioctl_addr;
`ifdef JTKICKER_IOCTL_CKSUM_EN
  logic [7:0] cksum;
`endif

  jtkicker_ioctl_tx #(.AW(AW), .GAP(GAP), .RDLAT(RDLAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_up(cmd_up), .cmd_ram(cmd_ram),
    .cmd_len(cmd_len), .host_din(host_din), .host_dv(host_dv), .host_rdy(host_rdy),
    .host_dout(host_dout), .host_ov(host_ov), .host_ordy(host_ordy), .busy(busy), .done(done),
`ifdef JTKICKER_IOCTL_CKSUM_EN
    .cksum(cksum),
`endif
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .ioctl_rom(ioctl_rom), .ioctl_ram(ioctl_ram), .ioctl_din(ioctl_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Game memory model: read data = (addr + 0x80) ^ key, two cycles behind the address.
  logic [AW-1:0] d1, d2;
  logic [7:0] din_key = 8'h00;
  always @(posedge clk) begin
    d1 <= ioctl_addr;
    d2 <= d1;
  end
  assign ioctl_din = (d2[7:0] + 8'h80) ^ din_key;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t exp_wr[$];
  logic [7:0] exp_up[$], tx_q[$], plan_bytes[$];
  int wr_cyc_log[$], up_cyc_log[$];
  logic [AW-1:0] wr_a_log[$];
  logic [7:0] wr_d_log[$], up_log[$];
  logic cur_up = 1'b0, cur_ram = 1'b0, ordy_always = 1'b0;
  int done_cnt = 0, last_wr_cyc = -1, last_up_cyc = -1;
  logic [7:0] exp_sum;

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      wr_t e;
      chk("rom_window", {31'd0, ioctl_rom}, {31'd0, busy & ~cur_ram});
      chk("ram_window", {31'd0, ioctl_ram}, {31'd0, busy & cur_ram});
      chk("rdy_outside_dl", {31'd0, host_rdy & ~(busy & ~cur_up)}, 32'd0);
      chk("wr_in_upload", {31'd0, ioctl_wr & cur_up}, 32'd0);
      if (done) done_cnt++;
      if (ioctl_wr) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(ioctl_addr), 32'(e.a));
          chk("wr_data", {24'd0, ioctl_dout}, {24'd0, e.d});
        end
        if (last_wr_cyc >= 0) chk("wr_spacing_ge_gap", {31'd0, (cyc - last_wr_cyc) >= GAP}, 32'd1);
        last_wr_cyc = cyc;
        wr_cyc_log.push_back(cyc); wr_a_log.push_back(ioctl_addr); wr_d_log.push_back(ioctl_dout);
      end
      if (host_ov && host_ordy) begin
        if (exp_up.size() == 0) chk("up_unexpected", 32'd1, 32'd0);
        else chk("up_data", {24'd0, host_dout}, {24'd0, exp_up.pop_front()});
        if (ordy_always && last_up_cyc >= 0) chk("up_rate", 32'(cyc - last_up_cyc), 32'(RDLAT + 2));
        last_up_cyc = cyc;
        up_log.push_back(host_dout); up_cyc_log.push_back(cyc);
      end
    end
  end

  int start_cyc, done_cyc;

  // Runs one command. Inputs change 1 time unit after each rising edge.
  task automatic run_cmd(input logic up, input logic ram, input int len, input int dv_pct,
                         input int ordy_pct, input int stall_len, input int repulse_at,
                         input int ordy_hold, input int rst_after);
    int dones0, budget, k, stall, hold;
    logic acc, got_done, did_rst, hold_ended;
    logic [7:0] b;
    exp_wr.delete(); exp_up.delete(); tx_q.delete();
    wr_cyc_log.delete(); wr_a_log.delete(); wr_d_log.delete(); up_log.delete(); up_cyc_log.delete();
    exp_sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (!up) begin
        b = (i < plan_bytes.size()) ? plan_bytes[i] : 8'($urandom);
        tx_q.push_back(b);
        exp_wr.push_back('{a: AW'(i), d: b});
      end else begin
        b = (8'(i) + 8'h80) ^ din_key;
        exp_up.push_back(b);
      end
      exp_sum = exp_sum + b;
    end
    cur_up = up; cur_ram = ram; last_wr_cyc = -1; last_up_cyc = -1;
    ordy_always = (ordy_pct == 100) && (ordy_hold == 0);
    dones0 = done_cnt;
    @(posedge clk); #1;
    cmd_up = up; cmd_ram = ram; cmd_len = AW'(len); cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    start_cyc = cyc;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    budget = 40 * len + 100;
    k = 0; stall = stall_len; hold = ordy_hold; got_done = 1'b0; did_rst = 1'b0; hold_ended = 1'b0;
    while (!got_done && k < budget) begin
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (rst_after > 0 && wr_a_log.size() == rst_after) begin
        rst_n = 1'b0; #1;
        chk("rst_rom", {31'd0, ioctl_rom}, 32'd0);
        chk("rst_ram", {31'd0, ioctl_ram}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr", {31'd0, ioctl_wr}, 32'd0);
        chk("rst_rdy", {31'd0, host_rdy}, 32'd0);
        chk("rst_addr", 32'(ioctl_addr), 32'd0);
        chk("rst_dout", {24'd0, ioctl_dout}, 32'd0);
        did_rst = 1'b1;
        break;
      end
      if (!up && stall > 0 && tx_q.size() == len - 1) begin
        host_dv = 1'b0;
        stall--;
        if (stall == 0) begin
          chk("stall_addr", 32'(ioctl_addr), 32'd1);
          chk("stall_wr_count", 32'(wr_a_log.size()), 32'd1);
        end
      end else begin
        host_dv = (tx_q.size() > 0) && ($urandom_range(99) < dv_pct);
      end
      host_din = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
      if (hold > 0 && host_ov) begin
        host_ordy = 1'b0;
        hold--;
        chk("hold_dout", {24'd0, host_dout}, {24'd0, exp_up[0]});
        hold_ended = (hold == 0);
      end else begin
        if (hold_ended) chk("hold_ov_kept", {31'd0, host_ov}, 32'd1);
        hold_ended = 1'b0;
        host_ordy = ($urandom_range(99) < ordy_pct);
      end
      cmd_start = (k == repulse_at);
      if (k == repulse_at) begin cmd_len = AW'(1); cmd_up = ~up; end
      acc = host_dv && host_rdy;
      @(posedge clk); #1;
      if (acc) void'(tx_q.pop_front());
      k++;
    end
    cmd_start = 1'b0; host_dv = 1'b0; host_ordy = 1'b0;
    if (did_rst) begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_done", 32'(done_cnt - dones0), 32'd0);
      chk("rst_still_idle", {31'd0, busy | ioctl_rom | ioctl_ram}, 32'd0);
      rst_n = 1'b1;
    end else begin
      chk("done_seen", {31'd0, got_done}, 32'd1);
`ifdef JTKICKER_IOCTL_CKSUM_EN
      if (got_done) chk("cksum", {24'd0, cksum}, {24'd0, exp_sum});
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 32'(done_cnt - dones0), 32'd1);
      chk("wr_all_seen", 32'(exp_wr.size()), 32'd0);
      chk("up_all_seen", 32'(exp_up.size()), 32'd0);
      chk("end_idle", {29'd0, busy, ioctl_rom, ioctl_ram}, 32'd0);
    end
  endtask

  initial begin
    #3;
    chk("reset_outs", {22'd0, busy, done, ioctl_wr, ioctl_rom, ioctl_ram, host_rdy, host_ov, 3'd0}, 32'd0);
    chk("reset_addr", 32'(ioctl_addr), 32'd0);
    chk("reset_data", {16'd0, ioctl_dout, host_dout}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Download of four fixed ROM bytes with the host never stalling
    plan_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(1'b0, 1'b0, 4, 100, 100, 0, -1, 0, 0);
    chk("t1_wr_count", 32'(wr_a_log.size()), 32'd4);
    for (int i = 0; i < wr_a_log.size() && i < 4; i++) begin
      chk("t1_addr", 32'(wr_a_log[i]), i);
      chk("t1_data", {24'd0, wr_d_log[i]}, {24'd0, plan_bytes[i]});
      if (i > 0) chk("t1_spacing", 32'(wr_cyc_log[i] - wr_cyc_log[i-1]), 32'd8);
    end
    plan_bytes.delete();

    // Host stalls for 20 cycles before the second byte
    run_cmd(1'b0, 1'b0, 4, 100, 100, 20, -1, 0, 0);
    if (wr_a_log.size() >= 2) begin
      chk("t2_addr1", 32'(wr_a_log[1]), 32'd1);
      chk("t2_stall_gap", {31'd0, (wr_cyc_log[1] - wr_cyc_log[0]) >= 20}, 32'd1);
    end else chk("t2_wr_count", 32'(wr_a_log.size()), 32'd4);

    // NVRAM upload of three bytes with the host holding host_ordy low for 5 cycles
    din_key = 8'h00;
    run_cmd(1'b1, 1'b1, 3, 100, 100, 0, -1, 5, 0);
    chk("t3_count", 32'(up_log.size()), 32'd3);
    if (up_log.size() == 3) begin
      chk("t3_b0", {24'd0, up_log[0]}, 32'h80);
      chk("t3_b1", {24'd0, up_log[1]}, 32'h81);
      chk("t3_b2", {24'd0, up_log[2]}, 32'h82);
    end

    // Upload with host_ordy tied high: one byte every RDLAT+2 cycles
    run_cmd(1'b1, 1'b0, 4, 100, 100, 0, -1, 0, 0);
    if (up_cyc_log.size() == 4) chk("t3b_rate", 32'(up_cyc_log[3] - up_cyc_log[0]), 32'd12);
    else chk("t3b_count", 32'(up_cyc_log.size()), 32'd4);

    // Zero-length command
    run_cmd(1'b0, 1'b0, 0, 100, 100, 0, -1, 0, 0);
    chk("t4_done_latency", {31'd0, (done_cyc - start_cyc) <= 2}, 32'd1);
    chk("t4_no_wr", 32'(wr_a_log.size()), 32'd0);
    chk("t4_no_rdy", {31'd0, host_rdy}, 32'd0);

    // cmd_start pulsed again in the middle of a download
    run_cmd(1'b0, 1'b0, 4, 100, 100, 0, 12, 0, 0);
    chk("t5_wr_count", 32'(wr_a_log.size()), 32'd4);

    // Reset after two of four bytes, then start over from address 0
    run_cmd(1'b0, 1'b1, 4, 100, 100, 0, -1, 0, 2);
    run_cmd(1'b0, 1'b1, 2, 100, 100, 0, -1, 0, 0);
    if (wr_a_log.size() > 0) chk("t6_restart_addr", 32'(wr_a_log[0]), 32'd0);
    else chk("t6_wr_count", 32'(wr_a_log.size()), 32'd2);

    // Randomized commands
    for (int r = 0; r < 12; r++) begin
      din_key = 8'($urandom);
      run_cmd(1'($urandom), 1'($urandom), int'($urandom_range(10, 1)),
              int'($urandom_range(100, 30)), (r % 3 == 0) ? 100 : int'($urandom_range(100, 30)),
              0, -1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
